// File: rtl/arb_defs_pkg.sv
// Shared sizes, state encoding and helpers for the 32-way result-mux arbiter.
package arb_defs_pkg;

    localparam int unsigned N_REQ = 32;
    localparam int unsigned SEL_W = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick_32.sv
// Rotating priority encoder: first set bit of req scanning upward from ptr, wrapping 31 -> 0.
module rr_pick_32
    import arb_defs_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[ptr + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_arbiter_32.sv
// Round-robin owner arbitration for the 32-input ALU result mux, with hold timeout.
module mux_arbiter_32
    import arb_defs_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [SEL_W-1:0] select,
    output logic             preempt
);

    localparam int unsigned CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam bit          TMO_EN   = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic               grant_valid_nxt;
    logic [SEL_W-1:0]   select_nxt;
    logic               preempt_nxt;

    logic               in_grant_c;
    logic               done_c;
    logic               timeout_c;
    logic [N_REQ-1:0]   pick_req_c;
    logic [SEL_W-1:0]   pick_ptr_c;
    logic               found_c;
    logic [SEL_W-1:0]   idx_c;

    // select doubles as the owner register; a dropped request is a release.
    assign in_grant_c = (state == ST_GRANT);
    assign done_c     = in_grant_c & (rel | ~req[select]);
    assign timeout_c  = in_grant_c & TMO_EN & (cnt == CNT_LAST);

    // While granted, look ahead for the successor so handoff needs no bubble.
    assign pick_req_c = in_grant_c ? (req & ~onehot(select)) : req;
    assign pick_ptr_c = in_grant_c ? (select + SEL_W'(1)) : ptr;

    rr_pick_32 u_pick (
        .req   (pick_req_c),
        .ptr   (pick_ptr_c),
        .found (found_c),
        .idx   (idx_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            select      <= '0;
            preempt     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            grant       <= grant_nxt;
            grant_valid <= grant_valid_nxt;
            select      <= select_nxt;
            preempt     <= preempt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        cnt_nxt         = cnt;
        grant_nxt       = grant;
        grant_valid_nxt = grant_valid;
        select_nxt      = select;
        preempt_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (found_c) begin
                    state_nxt       = ST_GRANT;
                    grant_nxt       = onehot(idx_c);
                    grant_valid_nxt = 1'b1;
                    select_nxt      = idx_c;
                    cnt_nxt         = '0;
                end
            end
            ST_GRANT: begin
                if (done_c || timeout_c) begin
                    ptr_nxt     = pick_ptr_c;
                    cnt_nxt     = '0;
                    // A release on the timeout edge is an ordinary end.
                    preempt_nxt = timeout_c & ~done_c;
                    if (found_c) begin
                        grant_nxt  = onehot(idx_c);
                        select_nxt = idx_c;
                    end else begin
                        state_nxt       = ST_IDLE;
                        grant_nxt       = '0;
                        grant_valid_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mux_arbiter_32.sv
// Scoreboard bench for mux_arbiter_32 (HOLD_MAX=4) with directed hand-computed vectors.
module tb_mux_arbiter_32;

    logic        clock;
    logic        reset;
    logic [31:0] req;
    logic        rel;
    logic [31:0] grant;
    logic        grant_valid;
    logic [4:0]  select;
    logic        preempt;

    typedef struct {
        int          tgt;
        int          id;
        logic [31:0] grant;
        logic        gv;
        logic [4:0]  sel;
        logic        pe;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   vec   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mux_arbiter_32 #(.HOLD_MAX(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .rel         (rel),
        .grant       (grant),
        .grant_valid (grant_valid),
        .select      (select),
        .preempt     (preempt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] g, input logic gv,
                         input logic [4:0] s, input logic pe);
        n_cmp++;
        if (grant !== g || grant_valid !== gv || select !== s || preempt !== pe) begin
            n_bad++;
            $display("FAIL %s: got grant=%h gv=%b sel=%0d pe=%b, want grant=%h gv=%b sel=%0d pe=%b",
                     name, grant, grant_valid, select, preempt, g, gv, s, pe);
        end
    endtask

    // Apply inputs for the next edge and queue the outputs expected after it.
    task automatic drive(input logic [31:0] r, input logic rl, input logic gv,
                         input logic [4:0] s, input logic pe);
        exp_t e;
        @(negedge clock);
        req   = r;
        rel   = rl;
        e.tgt = cyc + 1;
        e.id  = vec;
        vec++;
        e.grant = gv ? (32'(1) << s) : 32'h0;
        e.gv    = gv;
        e.sel   = s;
        e.pe    = pe;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation that is due this cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            while (sb.size() > 0 && sb[0].tgt <= cyc) begin
                e = sb.pop_front();
                if (e.tgt < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL vec%0d: expectation for cycle %0d seen at %0d", e.id, e.tgt, cyc);
                end else begin
                    check($sformatf("vec%0d", e.id), e.grant, e.gv, e.sel, e.pe);
                end
            end
        end
    end

    initial begin : stim
        logic [4:0]  owner;
        logic [31:0] r;
        reset = 1'b1;
        req   = '0;
        rel   = 1'b0;
        #12;
        check("reset_state", 32'h0, 1'b0, 5'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        // Single requester, release, then ptr=1 favours requester 1.
        drive(32'h1, 1'b0, 1'b1, 5'd0, 1'b0);
        drive(32'h1, 1'b1, 1'b0, 5'd0, 1'b0);
        drive(32'h3, 1'b0, 1'b1, 5'd1, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 5'd1, 1'b0);

        // Two requesters at opposite ends alternate with no idle cycle.
        r = 32'h8000_0001;
        drive(r, 1'b0, 1'b1, 5'd31, 1'b0);
        owner = 5'd31;
        for (int k = 0; k < 4; k++) begin
            drive(r, 1'b0, 1'b1, owner, 1'b0);
            drive(r, 1'b0, 1'b1, owner, 1'b0);
            owner = (owner == 5'd31) ? 5'd0 : 5'd31;
            drive(r, 1'b1, 1'b1, owner, 1'b0);
        end
        drive(32'h0, 1'b0, 1'b0, 5'd31, 1'b0);

        // All requesting, release every cycle: select walks 0..31 and wraps.
        r = 32'hFFFF_FFFF;
        drive(r, 1'b1, 1'b1, 5'd0, 1'b0);
        for (int i = 1; i <= 32; i++) drive(r, 1'b1, 1'b1, 5'(i), 1'b0);
        drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0);

        // Timeout after 4 cycles, preempt pulse, re-eligibility, release on timeout edge.
        drive(32'h6, 1'b0, 1'b1, 5'd1, 1'b0);
        repeat (3) drive(32'h6, 1'b0, 1'b1, 5'd1, 1'b0);
        drive(32'h6, 1'b0, 1'b1, 5'd2, 1'b1);
        drive(32'h6, 1'b0, 1'b1, 5'd2, 1'b0);
        drive(32'h6, 1'b1, 1'b1, 5'd1, 1'b0);
        repeat (3) drive(32'h6, 1'b0, 1'b1, 5'd1, 1'b0);
        drive(32'h6, 1'b1, 1'b1, 5'd2, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 5'd2, 1'b0);

        // Owner 5 drops its request: idle with select held.
        drive(32'h20, 1'b0, 1'b1, 5'd5, 1'b0);
        drive(32'h20, 1'b0, 1'b1, 5'd5, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 5'd5, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 5'd5, 1'b0);

        // Drive into a preempt cycle, then reset asynchronously mid-cycle.
        drive(32'h30, 1'b0, 1'b1, 5'd4, 1'b0);
        repeat (3) drive(32'h30, 1'b0, 1'b1, 5'd4, 1'b0);
        drive(32'h30, 1'b0, 1'b1, 5'd5, 1'b1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        req   = '0;
        #1;
        check("async_reset", 32'h0, 1'b0, 5'd0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        drive(32'h10, 1'b0, 1'b1, 5'd4, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 5'd4, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        #2;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_32.md
# mux_arbiter_32

Round-robin arbiter that shares the ALU's 32-input, 32-bit result multiplexer among up to 32 requesters. It accepts level requests, grants exactly one owner at a time, and drives the mux's 5-bit `select` with the owner's index. Ownership is held until the owner releases or drops its request, or until a hold-timeout preempts it. The block sits between the functional units that produce candidate results and the `mux_32` select input.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive cycles one owner may hold the grant; 0 disables the timeout.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  32  level request; bit i set means requester i wants the mux.
- `release`  in  1  current owner finished this cycle; ignored when no owner.
- `grant`  out  32  one-hot owner vector; all zero when idle.
- `grant_valid`  out  1  an owner exists this cycle.
- `select`  out  5  index of the owner, wired to the mux select.
- `preempt`  out  1  one-cycle pulse when the timeout revoked a grant.

## Operation
- Two states: IDLE, GRANT. Reset state is IDLE.
- Reset values: `grant`=0, `grant_valid`=0, `select`=0, `preempt`=0, priority pointer `ptr`=0, hold counter=0.
- Pick rule: the first set bit of `req`, scanning upward from `ptr` with wrap 31→0. `ptr` is the highest-priority index.
- IDLE: if `req`≠0, register owner=pick and go to GRANT with hold counter=0. Otherwise stay in IDLE.
- GRANT ends at the clock edge on which any of these holds:
  - `release`=1;
  - `req[owner]`=0 (a dropped request is treated as a release);
  - `HOLD_MAX`≠0 and counter=`HOLD_MAX`-1 (timeout).
  - Otherwise the counter increments and the owner holds.
- On end: `ptr` ← owner+1 mod 32. The next owner is picked from `req` with the old owner's bit masked, scanning from the new `ptr`. The next owner is granted on the same edge with no bubble, and the counter resets to 0. If none remain, go to IDLE.
- Timeout end: `preempt`=1 for exactly the following cycle. A release or request drop on the same edge as the timeout counts as a normal end: no `preempt`, release wins.
- In IDLE, `select` holds its last value; `grant`=0 keeps the mux output don't-care.
- The timed-out owner keeps its `req` bit set and is re-eligible once the rotation returns to it.
- `grant` is always one-hot or zero. `select` always equals the index of the set `grant` bit whenever `grant_valid`=1.

## Timing
- All outputs are registered; no combinational path from `req` or `release` to any output.
- Request latency: `req` first sampled high at edge t gives `grant` and `select` valid after edge t (one cycle).
- Handoff: owner end and new owner appear on the same edge, so consecutive owners occupy adjacent cycles.
- Maximum wait for a continuously requesting input: 31·`HOLD_MAX`+1 cycles when the timeout is enabled.
- Asynchronous `reset` mid-grant clears outputs immediately, without waiting for a clock. The first grant after reset deassertion uses `ptr`=0.

## Structure
- Shared definitions file `arb_defs`: `N_REQ`=32, `SEL_W`=5, state encodings `ST_IDLE`=0 and `ST_GRANT`=1.
- One combinational sub-module `rr_pick_32`: inputs `req[31:0]` and `ptr[4:0]`; outputs `found` and `idx[4:0]`. It is a rotating priority encoder and is instantiated once.
- Top level holds the state register, owner/`ptr`/counter registers, release and timeout logic, and output registers.

## Test plan
- Reset, then `req`=0x0000_0001 → after one edge `grant`=0x1, `select`=0, `grant_valid`=1; `release` pulse → next cycle `grant`=0 and `ptr`=1.
- `req`=0x8000_0001 held, `HOLD_MAX`=0, `release` pulsed every 3 cycles → owners alternate 0, 31, 0, 31 with no idle cycle between them.
- `req`=0x0000_0006, owner 1 never releases, `HOLD_MAX`=4 → owner 1 for exactly 4 cycles; `preempt` pulses once; then `select`=2.
- All 32 requests set, `release` every cycle → `select` steps 0,1,…,31,0 and wraps cleanly.
- Owner 5 drops `req[5]` with no `release`, no other requests → state returns to IDLE next edge; `select` holds 5 and `grant`=0.
- Assert `reset` asynchronously mid-grant → `grant`, `grant_valid`, `preempt` go low before the next edge; after release from reset, `req`=0x10 → `select`=4.
